// File: rtl/firebird7_in_gate1_tessent_data_observe_tdr.sv
// IJTAG data register for the firebird7_in_gate1 mux: controls select/data,
// observes functional data and keeps a sticky per-bit toggle record.
module firebird7_in_gate1_tessent_data_observe_tdr #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] functional_data_in,
    output logic             ijtag_select,
    output logic [WIDTH-1:0] ijtag_data_out
);

    localparam int unsigned L = 2 * WIDTH + 1;

    logic [L-1:0]     sr_q, sr_d;
    logic             upd_sel_q, upd_sel_d;
    logic [WIDTH-1:0] upd_data_q, upd_data_d;
    logic             so_q, so_d;
    logic [WIDTH-1:0] tog_q, tog_d;
    logic [WIDTH-1:0] prev_func_q, prev_func_d;
    logic [WIDTH-1:0] tog_now;

    always_comb begin
        // Includes a toggle seen on this very edge, so capture reports it.
        tog_now     = tog_q | (functional_data_in ^ prev_func_q);
        sr_d        = sr_q;
        upd_sel_d   = upd_sel_q;
        upd_data_d  = upd_data_q;
        so_d        = so_q;
        tog_d       = tog_now;
        prev_func_d = functional_data_in;

        if (ijtag_sel) begin
            if (ijtag_ce) begin
                sr_d  = {tog_now, functional_data_in, upd_sel_q};
                tog_d = '0;
            end else if (ijtag_se) begin
                sr_d = {ijtag_si, sr_q[L-1:1]};
                so_d = sr_q[0];
            end else if (ijtag_ue) begin
                upd_sel_d  = sr_q[0];
                upd_data_d = sr_q[WIDTH:1];
            end
        end
    end

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            sr_q        <= '0;
            upd_sel_q   <= 1'b0;
            upd_data_q  <= '0;
            so_q        <= 1'b0;
            tog_q       <= '0;
            prev_func_q <= functional_data_in;
        end else begin
            sr_q        <= sr_d;
            upd_sel_q   <= upd_sel_d;
            upd_data_q  <= upd_data_d;
            so_q        <= so_d;
            tog_q       <= tog_d;
            prev_func_q <= prev_func_d;
        end
    end

    assign ijtag_so       = so_q;
    assign ijtag_select   = upd_sel_q;
    assign ijtag_data_out = upd_data_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_observe_tdr.sv
// Scoreboard bench for the gate1 observe TDR: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_firebird7_in_gate1_tessent_data_observe_tdr;

    localparam int unsigned W = 3;

    logic         tck = 1'b0;
    logic         rst;
    logic         sel, ce, se, ue, si;
    logic         so;
    logic [W-1:0] func;
    logic         select_o;
    logic [W-1:0] data_o;

    firebird7_in_gate1_tessent_data_observe_tdr #(.WIDTH(W)) dut (
        .ijtag_tck          (tck),
        .ijtag_reset        (rst),
        .ijtag_sel          (sel),
        .ijtag_ce           (ce),
        .ijtag_se           (se),
        .ijtag_ue           (ue),
        .ijtag_si           (si),
        .ijtag_so           (so),
        .functional_data_in (func),
        .ijtag_select       (select_o),
        .ijtag_data_out     (data_o)
    );

    always #5 tck = ~tck;

    typedef struct {
        int unsigned cyc;
        int          kind;   // 0 select, 1 data_out, 2 so
        logic [31:0] exp;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int unsigned cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] act;
    logic [6:0]  wv;

    always @(posedge tck) cyc <= cyc + 1;

    always @(negedge tck) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                0:       act = {31'b0, select_o};
                1:       act = {29'b0, data_o};
                default: act = {31'b0, so};
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", e.nm, act, e.exp, cyc);
            end
        end
    end

    task automatic set_in(input logic s, input logic c, input logic sh, input logic u, input logic d);
        sel = s; ce = c; se = sh; ue = u; si = d;
    endtask

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    // Expected value of an output right after the next active edge.
    task automatic expect_out(input int kind, input logic [31:0] v, input string nm);
        exp_t x;
        x.cyc = cyc + 1; x.kind = kind; x.exp = v; x.nm = nm;
        sb.push_back(x);
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic shift_out(input logic [6:0] exp, input string nm);
        for (int i = 0; i < 7; i++) begin
            set_in(1, 0, 1, 0, 0);
            expect_out(2, {31'b0, exp[i]}, nm);
            tick();
        end
        set_in(0, 0, 0, 0, 0);
    endtask

    task automatic read_chain(input logic [6:0] exp, input string nm);
        set_in(1, 1, 0, 0, 0);
        tick();
        shift_out(exp, nm);
    endtask

    initial begin
        // Reset with func = 101
        func = 3'b101;
        rst  = 1'b1;
        set_in(0, 0, 0, 0, 0);
        expect_out(0, 0, "rst_select");
        expect_out(1, 0, "rst_data");
        expect_out(2, 0, "rst_so");
        tick();
        rst = 1'b0;
        read_chain(7'b0001010, "rst_capture");

        // Write select=1, data=110
        wv = 7'b0001101;
        for (int i = 0; i < 7; i++) begin
            set_in(1, 0, 1, 0, wv[i]);
            if (i == 6) begin
                expect_out(0, 0, "pre_upd_select");
                expect_out(1, 0, "pre_upd_data");
            end
            tick();
        end
        set_in(1, 0, 0, 1, 0);
        expect_out(0, 1, "upd_select");
        expect_out(1, 3'b110, "upd_data");
        tick();
        idle();

        // Readback with func = 011 stable
        func = 3'b011;
        idle();
        set_in(1, 1, 0, 0, 0);
        tick();
        read_chain(7'b0000111, "readback");

        // Sticky toggle: 000 -> 100 -> 000
        func = 3'b000;
        set_in(1, 1, 0, 0, 0);
        tick();
        func = 3'b100;
        idle();
        func = 3'b000;
        idle();
        read_chain(7'b1000001, "toggle_sticky");
        read_chain(7'b0000001, "toggle_cleared");

        // ce+se together: capture only, so holds
        set_in(1, 1, 0, 0, 0);
        tick();
        set_in(1, 0, 1, 0, 0);
        expect_out(2, 1, "pre_cese_so");
        tick();
        set_in(1, 1, 1, 0, 1);
        expect_out(2, 1, "cese_so_hold");
        tick();
        shift_out(7'b0000001, "cese_chain");

        // ue while deselected: outputs unchanged
        set_in(0, 0, 0, 1, 0);
        expect_out(0, 1, "desel_select");
        expect_out(1, 3'b110, "desel_data");
        tick();
        idle();

        // Reset during the 4th shift
        func = 3'b111;
        idle();
        set_in(1, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 1, 0, 1);
            if (i == 2) begin
                expect_out(2, 1, "shift3_so");
                expect_out(0, 1, "shift3_select");
            end
            tick();
        end
        rst = 1'b1;
        set_in(1, 0, 1, 0, 1);
        expect_out(0, 0, "midrst_select");
        expect_out(1, 0, "midrst_data");
        expect_out(2, 0, "midrst_so");
        tick();
        rst = 1'b0;

        // Toggle on the capture edge itself
        idle();
        func = 3'b110;
        read_chain(7'b0011100, "cap_edge_toggle");
        read_chain(7'b0001100, "cap_edge_cleared");

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d pending expected %0d", sb.size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/firebird7_in_gate1_tessent_data_observe_tdr.md
# firebird7_in_gate1_tessent_data_observe_tdr

IJTAG data register that drives the `ijtag_select` and `ijtag_data_in` inputs of the `firebird7_in_gate1` data mux. It also observes the functional data feeding that mux, so a single IJTAG scan both controls and reads back the mux path. It keeps a per-bit sticky toggle record of the functional data between captures for activity checks. It sits on the `gate1` IJTAG network between the SIB and the mux instances, and is clocked by TCK.

## Interface
Parameters:
- `WIDTH`, 3, functional/IJTAG data width (1..32).

Ports:
- `ijtag_tck`  in  1  clock; all state changes on rising edge.
- `ijtag_reset`  in  1  reset, synchronous and active-high.
- `ijtag_sel`  in  1  register selected on the active scan path.
- `ijtag_ce`  in  1  capture enable.
- `ijtag_se`  in  1  shift enable.
- `ijtag_ue`  in  1  update enable.
- `ijtag_si`  in  1  scan in.
- `ijtag_so`  out  1  scan out (registered).
- `functional_data_in`  in  WIDTH  functional data observed at the mux input.
- `ijtag_select`  out  1  drives the mux select (registered).
- `ijtag_data_out`  out  WIDTH  drives the mux `ijtag_data_in` (registered).

## Operation
- Shift register `sr[2*WIDTH:0]`, chain length L = 2*WIDTH+1. Bit layout:
  - `sr[0]` = select.
  - `sr[WIDTH:1]` = data.
  - `sr[2*WIDTH:WIDTH+1]` = toggle.
- Update registers `upd_sel` and `upd_data[WIDTH-1:0]` drive `ijtag_select` and `ijtag_data_out`.
- Observe state:
  - `prev_func[WIDTH-1:0]` holds `functional_data_in` from the previous cycle.
  - `tog[WIDTH-1:0]` is the sticky toggle record.
- Toggle tracking runs every cycle, independent of `ijtag_sel`:
  - `tog <= tog | (functional_data_in ^ prev_func)`.
  - `prev_func <= functional_data_in`.
- Scan operations are active only when `ijtag_sel`=1. Priority: reset > capture > shift > update > hold. Only the highest-priority asserted enable acts.
  - Capture (`ce`): `sr <= {tog | (functional_data_in ^ prev_func), functional_data_in, upd_sel}`. `tog` clears to 0 in the same cycle. A toggle in the capture cycle is reported in this capture and not carried over.
  - Shift (`se`): `sr <= {ijtag_si, sr[2*WIDTH:1]}`. Bit 0 exits first.
  - Update (`ue`): `upd_sel <= sr[0]`, `upd_data <= sr[WIDTH:1]`. Toggle bits are not used on update.
- When `ijtag_sel`=0, `sr`, `upd_*` and `ijtag_so` hold.
- `ijtag_so <= sr[0]` when a shift occurs, otherwise it holds. Effectively, `so` presents the bit shifted out on the previous shift cycle.

## Timing
- Reset (synchronous): in the cycle `ijtag_reset`=1 is sampled:
  - `sr`, `upd_sel`, `upd_data`, `ijtag_so` and `tog` are set to 0.
  - `prev_func` loads `functional_data_in`, so no spurious toggle is recorded in the first cycle after reset.
  - Outputs are 0 from the following edge: `ijtag_select`=0, i.e. the mux passes functional data.
- Reset mid-shift or mid-capture aborts the operation and the partial chain is discarded. Reset overrides all enables.
- Capture latency: 1 cycle to load `sr`. The first captured bit (select) appears on `ijtag_so` after the first shift edge.
- Full read: L shift cycles after capture. `so` streams select, then data LSB..MSB, then toggle LSB..MSB.
- Update takes effect on `ijtag_select`/`ijtag_data_out` one edge after `ue` is sampled. Outputs glitch-free: they change only on an update edge or on reset.
- Simultaneous `ce`+`se`: capture wins and no shift happens that cycle. Simultaneous `se`+`ue`: shift wins and no update happens.
- Shifting more than L bits wraps nothing: excess leading bits fall off and the last L bits shifted in are kept.

## Test plan
- Reset: drive `functional_data_in`=3'b101 and assert `ijtag_reset` for 1 cycle -> `ijtag_select`=0, `ijtag_data_out`=0, `ijtag_so`=0. A capture on the next cycle reads toggle=3'b000.
- Write path (WIDTH=3): shift in 7 bits LSB-first for select=1, data=3'b110, then `ue` -> next edge `ijtag_select`=1, `ijtag_data_out`=3'b110. No change before the update edge.
- Readback: with `upd_sel`=1 and func=3'b011 held stable, capture then 7 shifts -> `so` sequence 1,1,1,0,0,0,0.
- Toggle sticky: after a capture, drive func 3'b000→3'b100→3'b000, then capture+shift -> toggle field=3'b100. A second capture with func stable gives toggle=3'b000.
- Priority and deselect:
  - `ce`+`se` together -> capture only.
  - `ue` with `ijtag_sel`=0 -> outputs unchanged.
  - `ijtag_reset` during the 4th shift -> all outputs 0 next edge.
- Toggle in capture cycle: func changes bit0 on the same edge as `ce` -> captured toggle=3'b001, and a subsequent capture reads 3'b000.
